u_type_encoder: RTL and testbench

U_TYPE_ENCODER -- requirements
Module: u_type_encoder

---
 rtl/u_type_encoder.sv | 106 ++++++++++
 tb/tb_u_type_encoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/u_type_encoder.sv
// U-type instruction encoder: packs {imm, rd, opcode} into a 32-bit word,
// rejects non-LUI/AUIPC opcodes, and buffers results in a 2-entry FIFO.
module u_type_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [19:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_valid,
  output logic [6:0]  err_opcode,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam int DATA_W = 32;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Error counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              legal;
  logic              accept;
  logic              push;
  logic              reject;
  logic              pop;
  logic [DATA_W-1:0] enc_word;
  logic              rd_ptr_nx;
  logic [1:0]        count_nx;
  logic [DATA_W-1:0] head_nx;

  // Handshake decode and next-head selection from registered queue state.
  always_comb begin
    in_ready  = !rst && !flush && (count < 2'd2);
    out_valid = (count != 2'd0);
    legal     = (in_opcode == OP_LUI) || (in_opcode == OP_AUIPC);
    accept    = in_valid && in_ready;
    push      = accept && legal;
    reject    = accept && !legal;
    pop       = out_valid && out_ready;
    enc_word  = {in_imm, in_rd, in_opcode};
    rd_ptr_nx = pop ? ~rd_ptr : rd_ptr;
    case ({push, pop})
      2'b10:   count_nx = count + 2'd1;
      2'b01:   count_nx = count - 2'd1;
      default: count_nx = count;
    endcase
    // The new head is either an already stored entry or, when the write
    // slot becomes the head this edge, the word being pushed right now.
    head_nx = out_instr;
    if (count_nx != 2'd0) begin
      if (push && (wr_ptr == rd_ptr_nx)) head_nx = enc_word;
      else                               head_nx = mem[rd_ptr_nx];
    end
  end

  // Queue storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  // Queue control, registered head, and error/statistics state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      out_instr  <= '0;
      err_valid  <= 1'b0;
      err_opcode <= '0;
      enc_count  <= '0;
      err_count  <= '0;
    end else begin
      err_valid <= reject;
      if (reject) begin
        err_opcode <= in_opcode;
        err_count  <= sat_inc8(err_count);
      end
      if (push) enc_count <= enc_count + 16'd1;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        rd_ptr    <= rd_ptr_nx;
        count     <= count_nx;
        out_instr <= head_nx;
      end
    end
  end

endmodule

// File: tb/tb_u_type_encoder.sv
// Directed self-checking bench for u_type_encoder.
module tb_u_type_encoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, err_valid;
  logic [6:0]  in_opcode, err_opcode;
  logic [4:0]  in_rd;
  logic [19:0] in_imm;
  logic [31:0] out_instr;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  u_type_encoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_valid(err_valid), .err_opcode(err_opcode),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
    in_valid = v; in_opcode = op; in_rd = rd; in_imm = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 7'h00, 5'd0, 20'h0);
    step(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    n_cmp++; if ({err_valid, err_opcode, err_count} !== 16'h0) begin n_bad++; $display("FAIL reset_err got=%b/%h/%0d exp=0", err_valid, err_opcode, err_count); end
    n_cmp++; if (enc_count !== 16'h0) begin n_bad++; $display("FAIL reset_enc_count got=%0d exp=0", enc_count); end
    rst = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_lui();
    out_ready = 1'b1;
    drive(1'b1, 7'h37, 5'd5, 20'h12345);
    step();
    drive(1'b0, 7'h00, 5'd0, 20'h0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lui_valid got=%0b exp=1", out_valid); end
    n_cmp++; if (out_instr !== 32'h123452B7) begin n_bad++; $display("FAIL lui_instr got=%h exp=123452b7", out_instr); end
    n_cmp++; if (enc_count !== 16'd1) begin n_bad++; $display("FAIL lui_enc_count got=%0d exp=1", enc_count); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lui_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_auipc_illegal();
    out_ready = 1'b1;
    drive(1'b1, 7'h17, 5'd1, 20'hFFFFF);
    step();
    n_cmp++; if (out_instr !== 32'hFFFFF097 || out_valid !== 1'b1) begin n_bad++; $display("FAIL auipc_instr got=%h/%0b exp=fffff097/1", out_instr, out_valid); end
    drive(1'b1, 7'h33, 5'd3, 20'h00001);
    step();
    drive(1'b0, 7'h00, 5'd0, 20'h0);
    n_cmp++; if (err_valid !== 1'b1 || err_opcode !== 7'h33) begin n_bad++; $display("FAIL illegal_err got=%0b/%h exp=1/33", err_valid, err_opcode); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL illegal_err_count got=%0d exp=1", err_count); end
    n_cmp++; if (out_valid !== 1'b0 || enc_count !== 16'd2) begin n_bad++; $display("FAIL illegal_not_queued got=%0b/%0d exp=0/2", out_valid, enc_count); end
    step();
    n_cmp++; if (err_valid !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width got=%0b exp=0", err_valid); end
  endtask

  task automatic test_rd_zero();
    out_ready = 1'b1;
    drive(1'b1, 7'h37, 5'd0, 20'h00000);
    step();
    drive(1'b0, 7'h00, 5'd0, 20'h0);
    n_cmp++; if (out_instr !== 32'h00000037 || out_valid !== 1'b1 || err_valid !== 1'b0) begin n_bad++; $display("FAIL rd_zero got=%h/%0b/%0b exp=00000037/1/0", out_instr, out_valid, err_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    // A=LUI x2 0xAAAAA, B=AUIPC x3 0x00001, C=LUI x31 0x80000
    out_ready = 1'b0;
    drive(1'b1, 7'h37, 5'd2, 20'hAAAAA);
    step();
    drive(1'b1, 7'h17, 5'd3, 20'h00001);
    step();
    drive(1'b1, 7'h37, 5'd31, 20'h80000);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    step();
    n_cmp++; if (enc_count !== 16'd5 || out_instr !== 32'hAAAAA137) begin n_bad++; $display("FAIL full_hold got=%0d/%h exp=5/aaaaa137", enc_count, out_instr); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_instr !== 32'h00001197 || out_valid !== 1'b1) begin n_bad++; $display("FAIL order_b got=%h exp=00001197", out_instr); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL refill_ready got=%0b exp=1", in_ready); end
    step();
    drive(1'b0, 7'h00, 5'd0, 20'h0);
    n_cmp++; if (out_instr !== 32'h80000FB7 || out_valid !== 1'b1 || enc_count !== 16'd6) begin n_bad++; $display("FAIL order_c got=%h/%0b/%0d exp=80000fb7/1/6", out_instr, out_valid, enc_count); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL push_pop_count got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 7'h37, 5'd7, 20'h11111);
    step(); step();
    drive(1'b0, 7'h00, 5'd0, 20'h0);
    flush = 1'b1; out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    step();
    flush = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_state got=%0b/%0b exp=0/1", out_valid, in_ready); end
    n_cmp++; if (enc_count !== 16'd8 || err_count !== 8'd1) begin n_bad++; $display("FAIL flush_counts got=%0d/%0d exp=8/1", enc_count, err_count); end
  endtask

  task automatic test_err_saturate();
    logic [6:0] op;
    for (int i = 0; i < 256; i++) begin
      op = (i % 2 == 0) ? 7'h33 : 7'h13;
      drive(1'b1, op, 5'd0, 20'h0);
      step();
      if (i < 3) begin
        n_cmp++; if (err_valid !== 1'b1 || err_opcode !== op) begin n_bad++; $display("FAIL b2b_err_%0d got=%0b/%h exp=1/%h", i, err_valid, err_opcode, op); end
      end
    end
    drive(1'b0, 7'h00, 5'd0, 20'h0);
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 7'h17, 5'd9, 20'h55555);
    step(); step();
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_full got=%0b/%0b exp=1/0", out_valid, in_ready); end
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready got=%0b exp=0", in_ready); end
    step();
    drive(1'b0, 7'h00, 5'd0, 20'h0);
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || enc_count !== 16'h0 || err_count !== 8'h0 || err_opcode !== 7'h0 || err_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_state got=%0b/%h/%0d/%0d/%h exp=0", out_valid, out_instr, enc_count, err_count, err_opcode); end
    rst = 1'b0; flush = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_release_ready got=%0b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_lui();
    test_auipc_illegal();
    test_rd_zero();
    test_back_to_back();
    test_flush();
    test_err_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
